// File: rtl/seq_sll_unit_if.sv
// Start/ready handshake bundle for the sequential left shifter.
// The unit side uses slave; the issuing side uses master.
interface seq_sll_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] out;
  logic             ovf;
  logic             busy;
  logic             ready;

  modport master (
    output start, in, shamt,
    input  out, ovf, busy, ready
  );

  modport slave (
    input  start, in, shamt,
    output out, ovf, busy, ready
  );
endinterface

// File: rtl/seq_sll_unit.sv
// Multi-cycle logical left shifter: one bit position per clock, start/ready handshake,
// plus a sticky signed-overflow flag for in*2^shamt not fitting in WIDTH signed bits.
module seq_sll_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic          clock,
  input  logic          reset,
  seq_sll_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic [SHW-1:0]   r_count;
  logic             w_accept;

  // A differing top-bit pair means the next doubling leaves the signed range.
  function automatic logic f_sign_loss(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ^ v[WIDTH-2];
  endfunction

  assign w_accept = bus.start && (r_state != S_SHIFT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_out   <= bus.in;
            r_ovf   <= 1'b0;
            r_count <= bus.shamt;
            r_state <= (bus.shamt == '0) ? S_DONE : S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_out   <= {r_out[WIDTH-2:0], 1'b0};
          r_ovf   <= r_ovf | f_sign_loss(r_out);
          r_count <= r_count - 1'b1;
          if (r_count == SHW'(1)) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out   = r_out;
  assign bus.ovf   = r_ovf;
  assign bus.busy  = (r_state == S_SHIFT);
  assign bus.ready = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_sll_unit.sv
// Scoreboard bench for seq_sll_unit: stimulus pushes expected results, a negedge monitor
// pops and compares whenever ready is high, including the cycle at which ready appears.
module tb_seq_sll_unit;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             ovf;
    int               rdy_cyc;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];

  seq_sll_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  seq_sll_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value times 2^sh in wide signed arithmetic, then a range test.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input int sh, input int c);
    exp_t   m;
    longint v;
    longint maxv;
    maxv      = 64'sd2147483647;
    v         = longint'($signed(a)) * (longint'(1) << sh);
    m.out     = WIDTH'(longint'(a) * (longint'(1) << sh));
    m.ovf     = (v > maxv) || (v < -maxv - 1);
    m.rdy_cyc = c + sh + 1;
    return m;
  endfunction

  always @(negedge clock) begin
    if (reset === 1'b0 && bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", 64'(bus.out), 64'(e.out));
        check("ovf", 64'(bus.ovf), 64'(e.ovf));
        check("latency_cycle", 64'(cyc), 64'(e.rdy_cyc));
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input int sh, input bit push);
    bus.start = 1'b1;
    bus.in    = a;
    bus.shamt = SHW'(sh);
    if (push) sb.push_back(model(a, sh, cyc));
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int busy_exp, input string name);
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clock);
      if (bus.ready === 1'b1) seen = 1'b1;
      else if (bus.busy === 1'b1) busy_n++;
    end
    if (!seen) check({name, "_ready_timeout"}, 64'd0, 64'd1);
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(busy_exp));
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input int sh, input string name);
    exp_t m;
    m = model(a, sh, 0);
    issue(a, sh, 1'b1);
    wait_done(sh, name);
    check({name, "_hold_out"}, 64'(bus.out), 64'(m.out));
    check({name, "_hold_ovf"}, 64'(bus.ovf), 64'(m.ovf));
    check({name, "_idle_ready"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] a;
    int sh;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    bus.shamt = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run_op(32'h0000_0001, 5, "t1");
    run_op(32'h8000_0000, 0, "t2");
    run_op(32'h4000_0000, 1, "t3a");
    run_op(32'hC000_0000, 1, "t3b");
    run_op(32'hFFFF_FFFF, 31, "t3c");

    // Back-to-back: B issued in A's DONE cycle, then a start while B is busy.
    issue(32'd3, 2, 1'b1);
    repeat (2) begin @(posedge clock); #1; end
    check("b2b_a_ready", 64'(bus.ready), 64'd1);
    issue(32'd7, 3, 1'b1);
    check("b2b_b_busy", 64'(bus.busy), 64'd1);
    issue(32'hDEAD_BEEF, 1, 1'b0);
    wait_done(2, "b2b_b");
    check("b2b_b_hold", 64'(bus.out), 64'd56);
    repeat (4) @(posedge clock);
    #1;

    // Reset in the third SHIFT cycle of a 10-bit shift.
    issue(32'h0000_1234, 10, 1'b1);
    repeat (2) begin @(posedge clock); #1; end
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    void'(sb.pop_back());
    @(posedge clock);
    #1;
    check("abort_out", 64'(bus.out), 64'd0);
    check("abort_ovf", 64'(bus.ovf), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    run_op(32'd1, 1, "t5");

    for (int n = 0; n < 1000; n++) begin
      a  = $urandom;
      sh = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = {{20{a[11]}}, a[11:0]};
      run_op(a, sh, "rand");
    end

    repeat (3) @(posedge clock);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
